// File: rtl/prirv32_instr_encoder_if.sv
// Request/instruction handshake bundle for prirv32_instr_encoder.
// The encoder sits on the slave modport; its producer/consumer uses master.
interface prirv32_instr_encoder_if #(
    parameter int CNT_W = 16
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [5:0]       req_op_i;
    logic [4:0]       req_rd_i;
    logic [4:0]       req_rs1_i;
    logic [4:0]       req_rs2_i;
    logic [31:0]      req_imm_i;
    logic             instr_valid_o;
    logic             instr_ready_i;
    logic [31:0]      instr_o;
    logic             instr_err_o;
    logic [CNT_W-1:0] enc_count_o;
    logic [CNT_W-1:0] err_count_o;

    modport master (
        output req_valid_i, req_op_i, req_rd_i, req_rs1_i, req_rs2_i, req_imm_i, instr_ready_i,
        input  req_ready_o, instr_valid_o, instr_o, instr_err_o, enc_count_o, err_count_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_rd_i, req_rs1_i, req_rs2_i, req_imm_i, instr_ready_i,
        output req_ready_o, instr_valid_o, instr_o, instr_err_o, enc_count_o, err_count_o
    );
endinterface

// File: rtl/prirv32_instr_encoder.sv
// RV32I instruction encoder with immediate range checks and an in-order output FIFO.
// Define PRIRV32_ENC_CSR_EN to encode the CSR ops (41-46); otherwise they are illegal.
module prirv32_instr_encoder #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input logic                   clk_in,
    input logic                   rst,
    prirv32_instr_encoder_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                           OPC_JALR = 7'b1100111, OPC_BR = 7'b1100011, OPC_LD = 7'b0000011,
                           OPC_ST = 7'b0100011, OPC_IMM = 7'b0010011, OPC_OP = 7'b0110011,
                           OPC_SYS = 7'b1110011;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef enum logic [3:0] {
        FMT_BAD, FMT_U, FMT_J, FMT_I, FMT_S, FMT_B, FMT_SH, FMT_R, FMT_FIX, FMT_CSR
    } fmt_t;

    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic        i_ok, b_ok, j_ok, u_ok, sh_ok;

    fmt_t        fmt;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  opc;
    logic [31:0] fixed_word;
    logic [31:0] enc_word;
    logic        enc_bad;

    assign imm = bus.req_imm_i;
    assign rd  = bus.req_rd_i;
    assign rs1 = bus.req_rs1_i;
    assign rs2 = bus.req_rs2_i;

    // An immediate fits when every bit above the field's sign bit copies it
    assign i_ok  = (&imm[31:11]) | ~(|imm[31:11]);
    assign b_ok  = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    assign j_ok  = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
    assign u_ok  = ~(|imm[11:0]);
    assign sh_ok = ~(|imm[31:5]);

    always_comb begin
        fmt        = FMT_BAD;
        f3         = 3'b000;
        f7         = 7'b0000000;
        opc        = 7'b0000000;
        fixed_word = NOP;
        case (bus.req_op_i)
            6'd0:  begin fmt = FMT_U;  opc = OPC_LUI;   end
            6'd1:  begin fmt = FMT_U;  opc = OPC_AUIPC; end
            6'd2:  begin fmt = FMT_J;  opc = OPC_JAL;   end
            6'd3:  begin fmt = FMT_I;  opc = OPC_JALR;  f3 = 3'b000; end
            6'd4:  begin fmt = FMT_B;  opc = OPC_BR;    f3 = 3'b000; end
            6'd5:  begin fmt = FMT_B;  opc = OPC_BR;    f3 = 3'b001; end
            6'd6:  begin fmt = FMT_B;  opc = OPC_BR;    f3 = 3'b100; end
            6'd7:  begin fmt = FMT_B;  opc = OPC_BR;    f3 = 3'b101; end
            6'd8:  begin fmt = FMT_B;  opc = OPC_BR;    f3 = 3'b110; end
            6'd9:  begin fmt = FMT_B;  opc = OPC_BR;    f3 = 3'b111; end
            6'd10: begin fmt = FMT_I;  opc = OPC_LD;    f3 = 3'b000; end
            6'd11: begin fmt = FMT_I;  opc = OPC_LD;    f3 = 3'b001; end
            6'd12: begin fmt = FMT_I;  opc = OPC_LD;    f3 = 3'b010; end
            6'd13: begin fmt = FMT_I;  opc = OPC_LD;    f3 = 3'b100; end
            6'd14: begin fmt = FMT_I;  opc = OPC_LD;    f3 = 3'b101; end
            6'd15: begin fmt = FMT_S;  opc = OPC_ST;    f3 = 3'b000; end
            6'd16: begin fmt = FMT_S;  opc = OPC_ST;    f3 = 3'b001; end
            6'd17: begin fmt = FMT_S;  opc = OPC_ST;    f3 = 3'b010; end
            6'd18: begin fmt = FMT_I;  opc = OPC_IMM;   f3 = 3'b000; end
            6'd19: begin fmt = FMT_I;  opc = OPC_IMM;   f3 = 3'b010; end
            6'd20: begin fmt = FMT_I;  opc = OPC_IMM;   f3 = 3'b011; end
            6'd21: begin fmt = FMT_I;  opc = OPC_IMM;   f3 = 3'b100; end
            6'd22: begin fmt = FMT_I;  opc = OPC_IMM;   f3 = 3'b110; end
            6'd23: begin fmt = FMT_I;  opc = OPC_IMM;   f3 = 3'b111; end
            6'd24: begin fmt = FMT_SH; opc = OPC_IMM;   f3 = 3'b001; end
            6'd25: begin fmt = FMT_SH; opc = OPC_IMM;   f3 = 3'b101; end
            6'd26: begin fmt = FMT_SH; opc = OPC_IMM;   f3 = 3'b101; f7 = F7_ALT; end
            6'd27: begin fmt = FMT_R;  opc = OPC_OP;    f3 = 3'b000; end
            6'd28: begin fmt = FMT_R;  opc = OPC_OP;    f3 = 3'b000; f7 = F7_ALT; end
            6'd29: begin fmt = FMT_R;  opc = OPC_OP;    f3 = 3'b001; end
            6'd30: begin fmt = FMT_R;  opc = OPC_OP;    f3 = 3'b010; end
            6'd31: begin fmt = FMT_R;  opc = OPC_OP;    f3 = 3'b011; end
            6'd32: begin fmt = FMT_R;  opc = OPC_OP;    f3 = 3'b100; end
            6'd33: begin fmt = FMT_R;  opc = OPC_OP;    f3 = 3'b101; end
            6'd34: begin fmt = FMT_R;  opc = OPC_OP;    f3 = 3'b101; f7 = F7_ALT; end
            6'd35: begin fmt = FMT_R;  opc = OPC_OP;    f3 = 3'b110; end
            6'd36: begin fmt = FMT_R;  opc = OPC_OP;    f3 = 3'b111; end
            6'd37: begin fmt = FMT_FIX; fixed_word = 32'h0FF0_000F; end
            6'd38: begin fmt = FMT_FIX; fixed_word = 32'h0000_100F; end
            6'd39: begin fmt = FMT_FIX; fixed_word = 32'h0000_0073; end
            6'd40: begin fmt = FMT_FIX; fixed_word = 32'h0010_0073; end
`ifdef PRIRV32_ENC_CSR_EN
            6'd41: begin fmt = FMT_CSR; opc = OPC_SYS;  f3 = 3'b001; end
            6'd42: begin fmt = FMT_CSR; opc = OPC_SYS;  f3 = 3'b010; end
            6'd43: begin fmt = FMT_CSR; opc = OPC_SYS;  f3 = 3'b011; end
            6'd44: begin fmt = FMT_CSR; opc = OPC_SYS;  f3 = 3'b101; end
            6'd45: begin fmt = FMT_CSR; opc = OPC_SYS;  f3 = 3'b110; end
            6'd46: begin fmt = FMT_CSR; opc = OPC_SYS;  f3 = 3'b111; end
`endif
            default: fmt = FMT_BAD;
        endcase
    end

    // Assemble the word for the selected format; any range violation collapses it to a NOP
    always_comb begin
        enc_word = NOP;
        enc_bad  = 1'b0;
        case (fmt)
            FMT_U:   begin enc_word = {imm[31:12], rd, opc}; enc_bad = ~u_ok; end
            FMT_J:   begin enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc}; enc_bad = ~j_ok; end
            FMT_I:   begin enc_word = {imm[11:0], rs1, f3, rd, opc}; enc_bad = ~i_ok; end
            FMT_S:   begin enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc}; enc_bad = ~i_ok; end
            FMT_B:   begin enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc}; enc_bad = ~b_ok; end
            FMT_SH:  begin enc_word = {f7, imm[4:0], rs1, f3, rd, opc}; enc_bad = ~sh_ok; end
            FMT_R:   enc_word = {f7, rs2, rs1, f3, rd, opc};
            FMT_FIX: enc_word = fixed_word;
`ifdef PRIRV32_ENC_CSR_EN
            FMT_CSR: begin enc_word = {imm[11:0], rs1, f3, rd, opc}; enc_bad = |imm[31:12]; end
`endif
            default: enc_bad = 1'b1;
        endcase
        if (enc_bad) enc_word = NOP;
    end

    logic [31:0]      mem_word [FIFO_DEPTH];
    logic             mem_err  [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [31:0]      last_word;
    logic             last_err;
    logic [CNT_W-1:0] enc_count, err_count;
    logic             empty, full, push, pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = bus.req_valid_i & ~full;
    assign pop   = ~empty & bus.instr_ready_i;

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_word[wr_ptr[AW-1:0]] <= enc_word;
            mem_err[wr_ptr[AW-1:0]]  <= enc_bad;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_word <= '0;
            last_err  <= 1'b0;
            enc_count <= '0;
            err_count <= '0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                enc_count <= enc_count + CNT_ONE;
                if (enc_bad) err_count <= err_count + CNT_ONE;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_word <= mem_word[rd_ptr[AW-1:0]];
                last_err  <= mem_err[rd_ptr[AW-1:0]];
            end
        end
    end

    // With the FIFO empty the outputs keep showing whatever was consumed last
    assign bus.req_ready_o   = ~full;
    assign bus.instr_valid_o = ~empty;
    assign bus.instr_o       = empty ? last_word : mem_word[rd_ptr[AW-1:0]];
    assign bus.instr_err_o   = empty ? last_err  : mem_err[rd_ptr[AW-1:0]];
    assign bus.enc_count_o   = enc_count;
    assign bus.err_count_o   = err_count;
endmodule
